// File: rtl/spi_reg_ctrl_pkg.sv
// spi_reg_ctrl_pkg: shared state type and widths for the SPI register controller
package spi_reg_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;
  localparam int FRAME_W = 16;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
endpackage

// File: rtl/spi_reg_ctrl_tick.sv
// spi_reg_ctrl_tick: one-cycle half-period tick every CLK_DIV cycles while enabled, count restarts on enable
module spi_reg_ctrl_tick
  import spi_reg_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  logic [7:0] cnt;
  assign tick = en && (cnt == 8'(CLK_DIV - 1));
  always_ff @(posedge clk) begin
    if (rst || !en) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 8'd1;
  end
endmodule

// File: rtl/spi_reg_controller.sv
// spi_reg_controller: SPI mode-0 register access controller; define SPI_REG_CONTROLLER_READ_EN to capture cipo into rdata
module spi_reg_controller
  import spi_reg_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              sclk,
  output logic              ncs,
  output logic              copi,
  input  logic              cipo
);
  state_t state, state_n;
  logic [FRAME_W-1:0] sr;
  logic [4:0] bit_cnt;
  logic tick, accept, fall;
  assign accept = req_valid && req_ready;
  assign fall = tick && sclk;
  spi_reg_ctrl_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (state != IDLE),
    .tick(tick)
  );
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
  end
  always_comb begin
    state_n = state == IDLE  ? (accept ? SHIFT : IDLE) :
              state == SHIFT ? ((fall && bit_cnt == 5'd15) ? HOLD : SHIFT) :
              state == HOLD  ? (tick ? GAP : HOLD) :
              ((tick && bit_cnt == 5'(CS_GAP - 1)) ? IDLE : GAP);
  end
  always_comb begin
    req_ready = (state == IDLE) && !rst;
    ncs = !(state == SHIFT || state == HOLD);
    copi = (state == SHIFT) && sr[FRAME_W-1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk <= 1'b0;
      done <= 1'b0;
      sr <= '0;
      bit_cnt <= '0;
    end else begin
      sclk <= (state == SHIFT) && (tick ? !sclk : sclk);
      done <= (state == HOLD) && tick;
      if (accept) begin
        sr <= {req_write, req_addr, req_wdata & {DATA_W{req_write}}};
        bit_cnt <= '0;
      end else if (fall) begin
        sr <= sr << 1;
        bit_cnt <= bit_cnt + 5'd1;
      end else if (state == HOLD) begin
        bit_cnt <= '0;
      end else if (state == GAP && tick) begin
        bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end
`ifdef SPI_REG_CONTROLLER_READ_EN
  logic [DATA_W-1:0] rx;
  logic is_read;
  always_ff @(posedge clk) begin
    if (rst) begin
      rx <= '0;
      rdata <= '0;
      is_read <= 1'b0;
    end else begin
      if (accept) is_read <= !req_write;
      if (state == SHIFT && tick && !sclk && bit_cnt >= 5'd8) rx <= {rx[DATA_W-2:0], cipo};
      if (state == HOLD && tick && is_read) rdata <= rx;
    end
  end
`else
  logic unused;
  assign unused = cipo;
  assign rdata = '0;
`endif
endmodule
